// File: rtl/vec_op_sequencer.sv
// Vector operation sequencer: walks two source vectors in memory element by
// element, combines each pair (add or floor-average) and writes the result
// vector back through a single shared data-memory port, stalling the core
// while it runs.
module vec_op_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] src_a_base,
  input  logic [31:0] src_b_base,
  input  logic [31:0] dst_base,
  input  logic [7:0]  len,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_AVG = 3'b001;

  state_t      state;
  state_t      state_nx;

  logic [2:0]  op_q;
  logic        inv_q;
  logic [31:0] a_base_q;
  logic [31:0] b_base_q;
  logic [31:0] d_base_q;
  logic [7:0]  len_q;
  logic [7:0]  idx_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;

  logic        op_valid;
  logic [31:0] offset;
  logic [32:0] sum33;
  logic [31:0] result;
  logic        last_elem;

  assign op_valid  = (funct3 == F_ADD) || (funct3 == F_AVG);
  assign offset    = {22'd0, idx_q, 2'b00};
  assign sum33     = {1'b0, opa_q} + {1'b0, opb_q};
  assign result    = (op_q == F_AVG) ? sum33[32:1] : sum33[31:0];
  assign last_elem = (idx_q + 8'd1) == len_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and memory-port / status outputs
  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len == 8'd0 || !op_valid) state_nx = S_DONE;
          else                          state_nx = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_addr = a_base_q + offset;
        state_nx = S_RD_B;
      end
      S_RD_B: begin
        mem_addr = b_base_q + offset;
        state_nx = S_WR;
      end
      S_WR: begin
        mem_addr  = d_base_q + offset;
        // A reset arriving in this cycle must suppress the pending write,
        // so the enable is gated combinationally rather than only by state.
        mem_we    = !reset;
        mem_wdata = result;
        state_nx  = last_elem ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        done     = !reset;
        err      = !reset && inv_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy;

  // Operation latch, element index and operand capture
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      inv_q    <= 1'b0;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= funct3;
            inv_q    <= !op_valid;
            a_base_q <= src_a_base;
            b_base_q <= src_b_base;
            d_base_q <= dst_base;
            len_q    <= len;
            idx_q    <= '0;
          end
        end
        S_RD_A:  opa_q <= mem_rdata;
        S_RD_B:  opb_q <= mem_rdata;
        S_WR:    idx_q <= idx_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vec_op_sequencer.md
VEC_OP_SEQUENCER -- requirements
Module: vec_op_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request to begin a vector operation; sampled only in IDLE.
REQ-004 funct3  input  3  operation select: 000 = add_v, 001 = avg_v, others invalid.
REQ-005 src_a_base  input  32  byte address of vector A element 0.
REQ-006 src_b_base  input  32  byte address of vector B element 0.
REQ-007 dst_base  input  32  byte address of result element 0.
REQ-008 len  input  8  element count, 0..255.
REQ-009 mem_rdata  input  32  data memory read data, combinational from mem_addr.
REQ-010 mem_addr  output  32  data memory word address (byte address, word-aligned).
REQ-011 mem_we  output  1  data memory write enable; write occurs at the next rising edge.
REQ-012 mem_wdata  output  32  data memory write data.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 stall  output  1  core PC/register-write hold; equals busy.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  one-cycle pulse, coincident with done, for an invalid funct3.

Function
REQ-017 States SHALL be IDLE, RD_A, RD_B, WR, DONE.
REQ-018 IDLE with start=1 at an edge: latch funct3, the three bases and len; clear index i to 0; go to RD_A, or to DONE if len=0 or funct3 is invalid.
REQ-019 Invalid funct3 SHALL set err during the DONE cycle and perform no memory writes.
REQ-020 RD_A: mem_addr = a_base + 4*i; capture mem_rdata into opA at the edge; go to RD_B.
REQ-021 RD_B: mem_addr = b_base + 4*i; capture mem_rdata into opB at the edge; go to WR.
REQ-022 WR: mem_addr = dst_base + 4*i; mem_we = 1; mem_wdata = result. At the edge, i increments; go to DONE if i+1 = len, else go to RD_A.
REQ-023 add_v result SHALL be (opA + opB) mod 2^32.
REQ-024 avg_v result SHALL be the 33-bit unsigned sum opA + opB shifted right by 1 (floor, no overflow loss).
REQ-025 Address arithmetic SHALL be modulo 2^32; i*4 SHALL be formed as {i, 2'b00} zero-extended.
REQ-026 DONE: done = 1 for exactly one cycle; go to IDLE unconditionally.
REQ-027 mem_we SHALL be 0 in all states except WR; mem_addr and mem_wdata SHALL be 0 in IDLE and DONE.
REQ-028 start while not IDLE SHALL be ignored, including start asserted during DONE.
REQ-029 Latched operands SHALL NOT change while busy, regardless of input changes.
REQ-030 Latency: start accepted at edge k. Element n writes at edge k+3(n+1). done is high between edges k+3*len and k+3*len+1. For len=0 or invalid funct3, done is high between edges k and k+1.
REQ-031 Element order SHALL be ascending. Element i is written only after both of its reads, so in-place operation (dst_base = a_base or b_base) is correct.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE, i=0, opA=opB=0, busy=stall=done=err=mem_we=0, mem_addr=mem_wdata=0.
REQ-033 Reset during any state, including WR, SHALL abort the operation: no write at that edge, no done pulse.
REQ-034 reset SHALL take priority over start at the same edge.

Verification
REQ-035 add_v: len=3, A=[1,2,0xFFFFFFFF], B=[10,20,1] -> dst=[11,22,0]; done exactly once, 9 cycles after start is accepted; busy high for 10 cycles.
REQ-036 avg_v: A=[0xFFFFFFFF,3], B=[0xFFFFFFFF,4], len=2 -> dst=[0xFFFFFFFF,3]; err=0.
REQ-037 len=0 and funct3=010, each run separately -> done pulse in the first cycle after start; no mem_we asserted; err=1 only for funct3=010.
REQ-038 In-place add_v with dst_base = a_base, len=4 -> A[i] replaced by A[i]+B[i]; B unchanged; start pulses mid-run ignored.
REQ-039 reset asserted in the second WR cycle of a len=4 run -> only element 0 written; busy=0 next cycle; no done; a fresh start then runs normally.
REQ-040 Wrap: a_base=0xFFFFFFFC, len=2 -> second A read at address 0x00000000.
